core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 180 ++++++++++++++++++
 tb/tb_core_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and write-back control.
// Define CORE_SEQ_TIMEOUT_EN to bound memory waits with a TIMEOUT_CYC watchdog that halts with bus_err.
module core_seq #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
    } cls_t;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("core_seq: TIMEOUT_CYC must be within 1..65535");
    end

    state_t cur, nxt;
    cls_t   cls_d, cls_q;
    logic   legal_d, system_d;
    logic   set_illegal, set_bus_err;
    logic   wait_hit;

    // Opcode classification; the class is captured in DECODE so later states do not depend on the IR.
    always_comb begin
        cls_d    = C_ALU;
        legal_d  = 1'b1;
        system_d = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111: cls_d = C_ALU;
            7'b0000011:             cls_d = C_LOAD;
            7'b0100011:             cls_d = C_STORE;
            7'b1100011:             cls_d = C_BRANCH;
            7'b1101111:             cls_d = C_JAL;
            7'b1100111:             cls_d = C_JALR;
            7'b1110011: begin
                legal_d  = 1'b0;
                system_d = 1'b1;
            end
            default:                legal_d = 1'b0;
        endcase
    end

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wait_cnt;

    assign wait_hit = (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((nxt == S_FETCH && cur != S_FETCH) || (nxt == S_MEM && cur != S_MEM)) begin
            wait_cnt <= '0;
        end else if ((cur == S_FETCH && !imem_ack) || (cur == S_MEM && !dmem_ack)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign wait_hit = 1'b0;
`endif

    always_comb begin
        nxt         = cur;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        rf_we       = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (cur)
            S_IDLE: if (run) nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (wait_hit) begin
                    set_bus_err = 1'b1;
                    nxt         = S_HALT;
                end
            end
            S_DECODE: begin
                if (legal_d) begin
                    nxt = S_EXECUTE;
                end else begin
                    set_illegal = !system_d;
                    nxt         = S_HALT;
                end
            end
            S_EXECUTE: begin
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    nxt = S_MEM;
                end else if (cls_q == C_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                    nxt    = run ? S_FETCH : S_IDLE;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (dmem_ack) begin
                    if (cls_q == C_STORE) begin
                        pc_we = 1'b1;
                        nxt   = run ? S_FETCH : S_IDLE;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (wait_hit) begin
                    set_bus_err = 1'b1;
                    nxt         = S_HALT;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = (cls_q == C_JAL) ? 2'd1 : (cls_q == C_JALR) ? 2'd2 : 2'd0;
                nxt    = run ? S_FETCH : S_IDLE;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_IDLE;
            instret <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            cur <= nxt;
            if (pc_we) instret <= instret + 32'd1;
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cur == S_DECODE) cls_q <= cls_d;
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: per-cycle state/strobe vectors against hand-derived expectations.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        reset, run, branch_taken, imem_ack, dmem_ack;
    logic [6:0]  opcode;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        halted, illegal, bus_err;

    int n_cmp = 0;
    int n_err = 0;

    core_seq #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .state(state), .instret(instret), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [10:0] obs;
    logic [2:0]  flags;
    assign obs   = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we};
    assign flags = {halted, illegal, bus_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ov(input logic [2:0] st, input logic imr, dmr, dwe, irw, pcw,
                                       input logic [1:0] sel, input logic rfw);
        return {st, imr, dmr, dwe, irw, pcw, sel, rfw};
    endfunction

    // One clock cycle: drive inputs after the rising edge, check outputs at the falling edge.
    task automatic cyc(input string tag, input logic r, ia, da, bt, input logic [10:0] exp);
        run = r; imem_ack = ia; dmem_ack = da; branch_taken = bt;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [10:0] O_IDLE, O_FETCH, O_FACK, O_DEC, O_EXE, O_HALT;
    logic [6:0]  alu_ops [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        O_IDLE  = ov(3'd0, 0, 0, 0, 0, 0, 2'd0, 0);
        O_FETCH = ov(3'd1, 1, 0, 0, 0, 0, 2'd0, 0);
        O_FACK  = ov(3'd1, 1, 0, 0, 1, 0, 2'd0, 0);
        O_DEC   = ov(3'd2, 0, 0, 0, 0, 0, 2'd0, 0);
        O_EXE   = ov(3'd3, 0, 0, 0, 0, 0, 2'd0, 0);
        O_HALT  = ov(3'd6, 0, 0, 0, 0, 0, 2'd0, 0);
        alu_ops[0] = 7'b0010011; alu_ops[1] = 7'b0110111; alu_ops[2] = 7'b0010111;
        opcode = 7'b0110011;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_out", 32'(obs), 32'(O_IDLE));
        chk("rst_instret", instret, 0);
        chk("rst_flags", 32'(flags), 0);
        @(posedge clk); #1;

        // R-type ALU, zero-wait
        cyc("alu_idle", 1, 0, 0, 0, O_IDLE);
        cyc("alu_fetch", 1, 1, 0, 0, O_FACK);
        cyc("alu_dec", 1, 0, 0, 0, O_DEC);
        cyc("alu_exe", 1, 0, 0, 0, O_EXE);
        cyc("alu_wb", 0, 0, 0, 0, ov(3'd5, 0, 0, 0, 0, 1, 2'd0, 1));
        chk("alu_instret", instret, 1);

        // Load with dmem_ack delayed three cycles
        opcode = 7'b0000011;
        cyc("ld_idle", 1, 0, 0, 0, O_IDLE);
        cyc("ld_fetch", 1, 1, 0, 0, O_FACK);
        cyc("ld_dec", 1, 0, 0, 0, O_DEC);
        cyc("ld_exe", 1, 0, 0, 0, O_EXE);
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 1, 0, 0, 0, ov(3'd4, 0, 1, 0, 0, 0, 2'd0, 0));
        cyc("ld_mem_ack", 1, 0, 1, 0, ov(3'd4, 0, 1, 0, 0, 0, 2'd0, 0));
        cyc("ld_wb", 0, 0, 0, 0, ov(3'd5, 0, 0, 0, 0, 1, 2'd0, 1));
        chk("ld_instret", instret, 2);

        // Branch taken then not taken; stray acks while no request is pending
        opcode = 7'b1100011;
        cyc("br_idle", 1, 0, 1, 0, O_IDLE);
        cyc("br_fetch", 1, 1, 0, 0, O_FACK);
        cyc("br_dec_stray_ack", 1, 1, 1, 0, O_DEC);
        cyc("br_exe_taken", 1, 0, 0, 1, ov(3'd3, 0, 0, 0, 0, 1, 2'd1, 0));
        cyc("br2_fetch", 1, 1, 0, 0, O_FACK);
        cyc("br2_dec", 1, 0, 0, 0, O_DEC);
        cyc("br2_exe_not_taken", 0, 0, 0, 0, ov(3'd3, 0, 0, 0, 0, 1, 2'd0, 0));
        cyc("br_back_idle", 0, 0, 0, 0, O_IDLE);
        chk("br_instret", instret, 4);

        // JAL with one fetch wait, then JALR back to back
        opcode = 7'b1101111;
        cyc("jal_idle", 1, 0, 0, 0, O_IDLE);
        cyc("jal_fetch_wait", 1, 0, 0, 0, O_FETCH);
        cyc("jal_fetch_ack", 1, 1, 0, 0, O_FACK);
        cyc("jal_dec", 1, 0, 0, 0, O_DEC);
        cyc("jal_exe", 1, 0, 0, 0, O_EXE);
        cyc("jal_wb", 1, 0, 0, 0, ov(3'd5, 0, 0, 0, 0, 1, 2'd1, 1));
        opcode = 7'b1100111;
        cyc("jalr_fetch", 1, 1, 0, 0, O_FACK);
        cyc("jalr_dec", 1, 0, 0, 0, O_DEC);
        cyc("jalr_exe", 1, 0, 0, 0, O_EXE);
        cyc("jalr_wb", 0, 0, 0, 0, ov(3'd5, 0, 0, 0, 0, 1, 2'd2, 1));
        chk("jalr_instret", instret, 6);

        // Store with run dropped before MEM: must still retire, then idle
        opcode = 7'b0100011;
        cyc("st_idle", 1, 0, 0, 0, O_IDLE);
        cyc("st_fetch", 1, 1, 0, 0, O_FACK);
        cyc("st_dec", 1, 0, 0, 0, O_DEC);
        cyc("st_exe", 0, 0, 0, 0, O_EXE);
        cyc("st_mem_wait", 0, 0, 0, 0, ov(3'd4, 0, 1, 1, 0, 0, 2'd0, 0));
        cyc("st_mem_ack", 0, 0, 1, 0, ov(3'd4, 0, 1, 1, 0, 1, 2'd0, 0));
        cyc("st_idle_after", 0, 0, 0, 0, O_IDLE);
        chk("st_instret", instret, 7);

        // Reset in the middle of a fetch wait
        opcode = 7'b0110011;
        cyc("rf_idle", 1, 0, 0, 0, O_IDLE);
        cyc("rf_fetch", 1, 0, 0, 0, O_FETCH);
        reset = 1'b1;
        cyc("rf_fetch_in_reset", 1, 1, 0, 0, O_FACK);
        reset = 1'b0;
        cyc("rf_req_dropped", 0, 0, 0, 0, O_IDLE);
        chk("rf_instret", instret, 0);

        // Remaining WB-class opcodes
        foreach (alu_ops[k]) begin
            opcode = alu_ops[k];
            cyc("op_idle", 1, 0, 0, 0, O_IDLE);
            cyc("op_fetch", 1, 1, 0, 0, O_FACK);
            cyc("op_dec", 1, 0, 0, 0, O_DEC);
            cyc("op_exe", 1, 0, 0, 0, O_EXE);
            cyc("op_wb", 0, 0, 0, 0, ov(3'd5, 0, 0, 0, 0, 1, 2'd0, 1));
        end
        chk("op_instret", instret, 3);

        // Fetch that never completes
        opcode = 7'b0110011;
        cyc("to_idle", 1, 0, 0, 0, O_IDLE);
`ifdef CORE_SEQ_TIMEOUT_EN
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 1, 0, 0, 0, O_FETCH);
        cyc("to_halt", 1, 1, 1, 0, O_HALT);
        chk("to_flags", 32'(flags), 32'(3'b101));
`else
        for (int i = 0; i < 8; i++) cyc("to_fetch_wait", 1, 0, 0, 0, O_FETCH);
        chk("to_flags", 32'(flags), 0);
`endif
        do_reset();

        // System opcode halts without the illegal flag
        opcode = 7'b1110011;
        cyc("sys_idle", 1, 0, 0, 0, O_IDLE);
        cyc("sys_fetch", 1, 1, 0, 0, O_FACK);
        cyc("sys_dec", 1, 0, 0, 0, O_DEC);
        cyc("sys_halt", 1, 1, 1, 0, O_HALT);
        chk("sys_flags", 32'(flags), 32'(3'b100));
        do_reset();

        // Illegal opcode: halt is absorbing until reset clears every flag
        opcode = 7'b1111111;
        cyc("ill_idle", 1, 0, 0, 0, O_IDLE);
        cyc("ill_fetch", 1, 1, 0, 0, O_FACK);
        cyc("ill_dec", 1, 0, 0, 0, O_DEC);
        cyc("ill_halt", 1, 1, 1, 1, O_HALT);
        cyc("ill_halt_hold", 0, 1, 1, 0, O_HALT);
        cyc("ill_halt_hold2", 1, 0, 0, 0, O_HALT);
        chk("ill_flags", 32'(flags), 32'(3'b110));
        chk("ill_instret", instret, 0);
        do_reset();
        @(negedge clk);
        chk("ill_rst_out", 32'(obs), 32'(O_IDLE));
        chk("ill_rst_flags", 32'(flags), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
